// File: rtl/mem_line_initiator_pkg.sv
// rtl/mem_line_initiator_pkg.sv - shared types and helpers for the line memory initiator
// Purpose: bus widths, line access type, FSM state encoding and the line-align helper.
// Ports: none (package).
package mem_line_initiator_pkg;

   localparam int         LINE_W     = 128;
   localparam int         ADDR_W     = 32;
   localparam logic [1:0] MTYPE_LINE = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // A line is 16 bytes, so the byte offset within the line is dropped.
   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:4], 4'b0000};
   endfunction

endpackage

// File: rtl/mem_line_initiator_req_arbiter.sv
// rtl/mem_line_initiator_req_arbiter.sv - fixed-priority two-input request select
// Purpose: input a (demand) always wins over input b (prefetch) while enabled.
// Ports: en (arbitration allowed), a_valid/b_valid requests, a_ready/b_ready grants,
//        latch_en (a request is taken this cycle), sel_b (taken request is from b).
module mem_line_initiator_req_arbiter (
   input  logic en,
   input  logic a_valid,
   input  logic b_valid,
   output logic a_ready,
   output logic b_ready,
   output logic latch_en,
   output logic sel_b
);

   assign a_ready  = en;
   assign b_ready  = en & ~a_valid;
   // Only meaningful together with latch_en: with a idle, the taken request must be b.
   assign sel_b    = ~a_valid;
   assign latch_en = en & (a_valid | b_valid);

endmodule

// File: rtl/mem_line_initiator.sv
// rtl/mem_line_initiator.sv - initiator for the 128-bit line memory interface
// Purpose: arbitrates demand and prefetch line requests, drives the memory bus for a
//          fixed LAT cycles, then returns the line data with the request tag.
//          Optional macro MEM_INIT_PF_FILTER_EN drops prefetches that hit the last
//          demand refill line and adds the pf_drop_cnt output.
// Ports: clka/rst clock and async reset; dq_* demand request; pq_* prefetch request;
//        rs_* response; mem_* line memory bus; pf_drop_cnt (filter build only).
module mem_line_initiator
   import mem_line_initiator_pkg::*;
#(
   parameter int LAT   = 4,
   parameter int TAG_W = 4
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              dq_valid,
   output logic              dq_ready,
   input  logic              dq_we,
   input  logic [ADDR_W-1:0] dq_addr,
   input  logic [LINE_W-1:0] dq_data,
   input  logic [TAG_W-1:0]  dq_tag,
   input  logic              pq_valid,
   output logic              pq_ready,
   input  logic [ADDR_W-1:0] pq_addr,
   input  logic [TAG_W-1:0]  pq_tag,
   output logic              rs_valid,
   input  logic              rs_ready,
   output logic [LINE_W-1:0] rs_data,
   output logic [TAG_W-1:0]  rs_tag,
   output logic              rs_pf,
   output logic              rs_we,
`ifdef MEM_INIT_PF_FILTER_EN
   output logic [15:0]       pf_drop_cnt,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_din,
   output logic              mem_we,
   output logic [1:0]        mem_mtype,
   input  logic [LINE_W-1:0] mem_dout
);

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] data_q;
   logic [LINE_W-1:0] rdata_q;
   logic [TAG_W-1:0]  tag_q;
   logic              we_q;
   logic              pf_q;

   logic arb_en;
   logic latch_en;
   logic sel_pf;
   logic drop;
   logic issue;
   logic expire;

   assign arb_en = (state_q == IDLE);

   mem_line_initiator_req_arbiter u_arb (
      .en       (arb_en),
      .a_valid  (dq_valid),
      .b_valid  (pq_valid),
      .a_ready  (dq_ready),
      .b_ready  (pq_ready),
      .latch_en (latch_en),
      .sel_b    (sel_pf)
   );

`ifdef MEM_INIT_PF_FILTER_EN
   logic [ADDR_W-1:0] last_line_q;
   logic              last_vld_q;

   // A prefetch of the line a demand refill just fetched is redundant.
   assign drop = latch_en & sel_pf & last_vld_q & (line_align(pq_addr) == last_line_q);

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         last_line_q <= '0;
         last_vld_q  <= 1'b0;
         pf_drop_cnt <= '0;
      end else begin
         if (latch_en & ~sel_pf & ~dq_we) begin
            last_line_q <= line_align(dq_addr);
            last_vld_q  <= 1'b1;
         end
         if (drop && (pf_drop_cnt != 16'hFFFF)) begin
            pf_drop_cnt <= pf_drop_cnt + 16'd1;
         end
      end
   end
`else
   assign drop = 1'b0;
`endif

   // A dropped prefetch is still handshaken but never leaves IDLE.
   assign issue  = latch_en & ~drop;
   assign expire = (state_q == BUSY) && (cnt_q == 4'd0);

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // mem_we is decoded from state so that reset removes it without waiting for a clock.
   always_comb begin
      state_d  = state_q;
      rs_valid = 1'b0;
      mem_we   = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (expire) begin
               mem_we  = we_q;
               state_d = RESP;
            end
         end
         RESP: begin
            rs_valid = 1'b1;
            if (rs_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         tag_q   <= '0;
         we_q    <= 1'b0;
         pf_q    <= 1'b0;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
      end else begin
         if (issue) begin
            addr_q <= sel_pf ? line_align(pq_addr) : line_align(dq_addr);
            data_q <= sel_pf ? '0 : dq_data;
            tag_q  <= sel_pf ? pq_tag : dq_tag;
            we_q   <= ~sel_pf & dq_we;
            pf_q   <= sel_pf;
            cnt_q  <= CNT_INIT;
         end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (expire) begin
            rdata_q <= we_q ? '0 : mem_dout;
         end
      end
   end

   // The request latch doubles as the bus drive and the response fields, which keeps
   // them stable from issue until the response handshake.
   assign mem_addr  = addr_q;
   assign mem_din   = data_q;
   assign mem_mtype = MTYPE_LINE;
   assign rs_data   = rdata_q;
   assign rs_tag    = tag_q;
   assign rs_pf     = pf_q;
   assign rs_we     = we_q;

endmodule

// File: doc/mem_line_initiator.md
Name: mem_line_initiator

Overview:
- Initiator side of the 128-bit line memory interface used by the data-side memory model: addr[31:0], din[127:0], we, dout[127:0], mtype[1:0].
- Accepts line requests from the cache controller on two ports:
  - a demand port for refills and writebacks;
  - a prefetch port for reads only.
- Arbitrates between the two ports, drives the memory bus, emulates a fixed access latency, and returns line data with a per-request tag.
- Sits between the cache/prefetcher and the memory model.

Parameters:
- LAT, 4: cycles the address is held on the bus before read data is sampled or a write is committed; legal range 1..15.
- TAG_W, 4: width of the request tag.

Ports:
- clka  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dq_valid  in  1  demand request valid.
- dq_ready  out  1  demand request accepted this cycle.
- dq_we  in  1  1 = writeback, 0 = refill.
- dq_addr  in  32  demand byte address.
- dq_data  in  128  writeback line.
- dq_tag  in  TAG_W  demand tag.
- pq_valid  in  1  prefetch read valid.
- pq_ready  out  1  prefetch accepted.
- pq_addr  in  32  prefetch byte address.
- pq_tag  in  TAG_W  prefetch tag.
- rs_valid  out  1  response valid.
- rs_ready  in  1  response accepted.
- rs_data  out  128  read line; 0 for writes.
- rs_tag  out  TAG_W  tag of the completed request.
- rs_pf  out  1  response belongs to a prefetch.
- rs_we  out  1  response is a write acknowledge.
- mem_addr  out  32  memory address.
- mem_din  out  128  memory write data.
- mem_we  out  1  memory write enable.
- mem_mtype  out  2  access size; constant 2'b11 (line).
- mem_dout  in  128  memory read data, combinational from mem_addr.

Behaviour:
- Reset values:
  - outputs: rs_valid=0, mem_we=0, mem_addr=0, mem_din=0, rs_data=0, rs_tag=0, rs_pf=0, rs_we=0.
  - FSM: IDLE, latency counter 0.
- FSM states: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - dq_ready=1, and pq_ready = ~dq_valid. Demand has strict priority over prefetch.
  - On an accepted request:
    - latch the address with bits [3:0] forced to 0, plus data, tag, we and pf;
    - drive mem_addr from the latch on the next cycle;
    - load the counter with LAT-1;
    - go to BUSY.
- BUSY:
  - mem_addr and mem_din are held stable.
  - The counter decrements each cycle.
  - When the counter reaches 0:
    - write: mem_we=1 for exactly that one cycle;
    - read: mem_dout is captured into rs_data;
    - go to RESP.
- RESP:
  - rs_valid=1, and it holds with all rs_* fields stable until rs_ready.
  - On rs_valid & rs_ready, go to IDLE. dq_ready and pq_ready are 0 in that cycle.
- Latency: accept cycle to rs_valid = LAT+1 cycles.
- Ready signals: dq_ready and pq_ready are 0 outside IDLE, so only one request is outstanding at a time.
- Addresses with bit 31 set pass through unchanged. The memory model returns 0 and ignores writes outside its window; this block does no range checking.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_we drops asynchronously. The in-flight request is lost and no response is produced.
- A simultaneous dq_valid and pq_valid in IDLE takes the demand. The prefetch remains pending and is served in the next IDLE.

Optional Feature:
- Macro MEM_INIT_PF_FILTER_EN:
  - A one-entry register holds the line address of the last demand refill.
  - A prefetch whose line address matches it is accepted (pq_ready=1) but dropped: no bus access and no response.
  - A saturating 16-bit output port pf_drop_cnt counts drops; it resets to 0.
- Without the macro: pf_drop_cnt is absent and every prefetch is issued.

Decomposition:
- Shared package:
  - LINE_W=128, ADDR_W=32, MTYPE_LINE=2'b11;
  - FSM state enum {IDLE, BUSY, RESP};
  - line-align function (clears bits [3:0]).
- Sub-module req_arbiter: fixed-priority two-input valid/ready select with latch-enable output.

Test Plan:
- Refill read, LAT=4:
  - stimulus: dq addr 0x0000_0104, memory preloaded at 0x100 with 0x00112233_44556677_8899AABB_CCDDEEFF;
  - response: mem_addr=0x100, rs_valid at cycle 5, rs_data equals the preload, rs_tag echoed, rs_pf=0.
- Writeback:
  - stimulus: dq_we=1, addr 0x200, data 0xA5 repeated;
  - response: a single mem_we pulse at cycle 4, rs_we=1; a subsequent read of 0x200 returns the 0xA5 pattern.
- Simultaneous dq_valid and pq_valid:
  - response: demand served first and prefetch served next; rs_pf sequence is 0 then 1, and the tags are in order.
- Response backpressure:
  - stimulus: rs_ready=0 for 6 cycles;
  - response: rs_* stable; dq_ready=0 throughout; the new request is accepted only after the handshake.
- Reset mid-operation:
  - stimulus: rst asserted in BUSY during a write, before the counter expires;
  - response: no mem_we pulse, no response, dq_ready=1 after reset.
- With MEM_INIT_PF_FILTER_EN:
  - stimulus: demand refill 0x300, then prefetch 0x308;
  - response: the prefetch is dropped with no bus access; pf_drop_cnt=1.
